// File: rtl/usb_ep0_setup_ctrl_if.sv
// Bus between usb_handshake_multiplexer and the EP0 setup controller.
// The master modport is the multiplexer side; the slave modport is the controller.
interface usb_ep0_setup_ctrl_if;
  logic [23:0] token_in;
  logic        token_in_strb;
  logic [7:0]  data_in;
  logic        data_in_strb;
  logic        data_in_end;
  logic        data_in_fail;
  logic [7:0]  pid;
  logic [7:0]  data_o;
  logic        data_o_start_stop;
  logic        data_o_strb;
  logic        data_o_fail;
  logic [6:0]  dev_addr;
  logic        configured;
  logic        setup_valid;
  logic        req_unsupported;
  logic [7:0]  bm_request_type;
  logic [7:0]  b_request;
  logic [15:0] w_value;
  logic [15:0] w_index;
  logic [15:0] w_length;

  modport slave (
    input  token_in, token_in_strb, data_in, data_in_strb, data_in_end,
           data_in_fail, pid, data_o_fail,
    output data_o, data_o_start_stop, data_o_strb, dev_addr, configured,
           setup_valid, req_unsupported, bm_request_type, b_request,
           w_value, w_index, w_length
  );

  modport master (
    output token_in, token_in_strb, data_in, data_in_strb, data_in_end,
           data_in_fail, pid, data_o_fail,
    input  data_o, data_o_start_stop, data_o_strb, dev_addr, configured,
           setup_valid, req_unsupported, bm_request_type, b_request,
           w_value, w_index, w_length
  );
endinterface

// File: rtl/usb_ep0_setup_ctrl.sv
// EP0 control stage: captures SETUP packets, decodes the request and answers
// SET_ADDRESS / SET_CONFIGURATION with a zero-length DATA1 status packet.
module usb_ep0_setup_ctrl #(
  parameter logic [3:0]  ENDP           = 4'd0,
  parameter logic [15:0] STATUS_TIMEOUT = 16'd60000
) (
  input logic                 clk,
  input logic                 rst,
  usb_ep0_setup_ctrl_if.slave bus
);

  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [1:0] {IDLE, SETUP_RX, STATUS_IN, TX_END} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_ADDR, REQ_CONF} req_t;

  state_t      state_q, state_d;
  req_t        pend_q, pend_d;
  logic [3:0]  byteCnt_q, byteCnt_d;
  logic [63:0] stage_q, stage_d;
  logic        bad_q, bad_d;
  logic [15:0] timer_q, timer_d;
  logic        txPhase_q, txPhase_d;
  logic [7:0]  dataO_q, dataO_d;
  logic        startStop_q, startStop_d;
  logic [6:0]  devAddr_q, devAddr_d;
  logic        configured_q, configured_d;
  logic        setupValid_q, setupValid_d;
  logic        reqUnsup_q, reqUnsup_d;
  logic [7:0]  bmReqType_q, bmReqType_d;
  logic [7:0]  bReq_q, bReq_d;
  logic [15:0] wValue_q, wValue_d;
  logic [15:0] wIndex_q, wIndex_d;
  logic [15:0] wLength_q, wLength_d;

  logic        tokMatch;
  logic [7:0]  tokPid;
  logic [7:0]  stReqType, stReq;
  logic [15:0] stValue, stIndex, stLength;
  logic        stNoData;
  logic        unused_crc;

  // The CRC5 has already been checked upstream.
  assign unused_crc = ^bus.token_in[23:19];

  assign tokPid   = bus.token_in[7:0];
  assign tokMatch = bus.token_in_strb && (bus.token_in[14:8] == devAddr_q)
                    && (bus.token_in[18:15] == ENDP);

  assign stReqType = stage_q[7:0];
  assign stReq     = stage_q[15:8];
  assign stValue   = {stage_q[31:24], stage_q[23:16]};
  assign stIndex   = {stage_q[47:40], stage_q[39:32]};
  assign stLength  = {stage_q[63:56], stage_q[55:48]};
  assign stNoData  = (stReqType == 8'd0) && (stLength == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= REQ_NONE;
      byteCnt_q    <= '0;
      stage_q      <= '0;
      bad_q        <= 1'b0;
      timer_q      <= '0;
      txPhase_q    <= 1'b0;
      dataO_q      <= '0;
      startStop_q  <= 1'b0;
      devAddr_q    <= '0;
      configured_q <= 1'b0;
      setupValid_q <= 1'b0;
      reqUnsup_q   <= 1'b0;
      bmReqType_q  <= '0;
      bReq_q       <= '0;
      wValue_q     <= '0;
      wIndex_q     <= '0;
      wLength_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      byteCnt_q    <= byteCnt_d;
      stage_q      <= stage_d;
      bad_q        <= bad_d;
      timer_q      <= timer_d;
      txPhase_q    <= txPhase_d;
      dataO_q      <= dataO_d;
      startStop_q  <= startStop_d;
      devAddr_q    <= devAddr_d;
      configured_q <= configured_d;
      setupValid_q <= setupValid_d;
      reqUnsup_q   <= reqUnsup_d;
      bmReqType_q  <= bmReqType_d;
      bReq_q       <= bReq_d;
      wValue_q     <= wValue_d;
      wIndex_q     <= wIndex_d;
      wLength_q    <= wLength_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    byteCnt_d    = byteCnt_q;
    stage_d      = stage_q;
    bad_d        = bad_q;
    timer_d      = timer_q;
    txPhase_d    = txPhase_q;
    dataO_d      = 8'd0;
    startStop_d  = 1'b0;
    devAddr_d    = devAddr_q;
    configured_d = configured_q;
    setupValid_d = 1'b0;
    reqUnsup_d   = 1'b0;
    bmReqType_d  = bmReqType_q;
    bReq_d       = bReq_q;
    wValue_d     = wValue_q;
    wIndex_d     = wIndex_q;
    wLength_d    = wLength_q;

    // A SETUP for us restarts capture from any state and abandons a pending request.
    if (tokMatch && tokPid == PID_SETUP) begin
      state_d   = SETUP_RX;
      pend_d    = REQ_NONE;
      byteCnt_d = '0;
      stage_d   = '0;
      bad_d     = 1'b0;
      timer_d   = '0;
      txPhase_d = 1'b0;
    end else begin
      case (state_q)
        SETUP_RX: begin
          if (bus.data_in_fail) begin
            state_d = IDLE;
          end else if (bus.data_in_end) begin
            state_d = IDLE;
            if (byteCnt_q == 4'd8 && !bad_q) begin
              bmReqType_d  = stReqType;
              bReq_d       = stReq;
              wValue_d     = stValue;
              wIndex_d     = stIndex;
              wLength_d    = stLength;
              setupValid_d = 1'b1;
              timer_d      = '0;
              if (stNoData && stReq == 8'd5) begin
                pend_d  = REQ_ADDR;
                state_d = STATUS_IN;
              end else if (stNoData && stReq == 8'd9) begin
                pend_d  = REQ_CONF;
                state_d = STATUS_IN;
              end else begin
                reqUnsup_d = 1'b1;
              end
            end
          end else if (bus.data_in_strb) begin
            if (byteCnt_q < 4'd8)
              stage_d[{byteCnt_q[2:0], 3'b000} +: 8] = bus.data_in;
            if (byteCnt_q == 4'd0 && bus.pid != PID_DATA0)
              bad_d = 1'b1;
            if (byteCnt_q != 4'd9)
              byteCnt_d = byteCnt_q + 4'd1;
          end
        end
        STATUS_IN: begin
          if (tokMatch && tokPid == PID_IN) begin
            startStop_d = 1'b1;
            dataO_d     = PID_DATA1;
            txPhase_d   = 1'b0;
            state_d     = TX_END;
          end else if (timer_q == STATUS_TIMEOUT - 16'd1) begin
            state_d = IDLE;
            pend_d  = REQ_NONE;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        TX_END: begin
          // The new address only takes effect once the ZLP has gone out cleanly.
          if (bus.data_o_fail) begin
            state_d = STATUS_IN;
            timer_d = '0;
          end else if (!txPhase_q) begin
            startStop_d = 1'b1;
            txPhase_d   = 1'b1;
          end else begin
            state_d = IDLE;
            pend_d  = REQ_NONE;
            if (pend_q == REQ_ADDR)
              devAddr_d = wValue_q[6:0];
            else if (pend_q == REQ_CONF)
              configured_d = (wValue_q[7:0] != 8'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_o            = dataO_q;
  assign bus.data_o_start_stop = startStop_q;
  assign bus.data_o_strb       = 1'b0;
  assign bus.dev_addr          = devAddr_q;
  assign bus.configured        = configured_q;
  assign bus.setup_valid       = setupValid_q;
  assign bus.req_unsupported   = reqUnsup_q;
  assign bus.bm_request_type   = bmReqType_q;
  assign bus.b_request         = bReq_q;
  assign bus.w_value           = wValue_q;
  assign bus.w_index           = wIndex_q;
  assign bus.w_length          = wLength_q;

endmodule

// File: tb/tb_usb_ep0_setup_ctrl.sv
// Randomized scoreboard bench for usb_ep0_setup_ctrl; a reference model of
// the control-transfer rules predicts setup reports, ZLPs and address/config.
module tb_usb_ep0_setup_ctrl;

  localparam logic [15:0] TIMEOUT   = 16'd300;
  localparam logic [7:0]  PID_SETUP = 8'h2D;
  localparam logic [7:0]  PID_IN    = 8'h69;
  localparam logic [7:0]  PID_D0    = 8'hC3;
  localparam logic [7:0]  PID_D1    = 8'h4B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_ep0_setup_ctrl_if bus();

  usb_ep0_setup_ctrl #(.ENDP(4'd0), .STATUS_TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  bm;
    logic [7:0]  br;
    logic [15:0] wv;
    logic [15:0] wi;
    logic [15:0] wl;
    logic        unsup;
  } setupExp_t;

  setupExp_t  setupQ[$];
  logic [7:0] txQ[$];
  int         vectors = 0;
  int         miscompares = 0;

  // Reference model: device-level view of address, configuration and pending request.
  logic [6:0]  mAddr;
  logic        mConf;
  int          mPend;
  logic [15:0] mPendVal;
  setupExp_t   mLast;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    logic [7:0] extra;
    extra = 8'($urandom);
    return {extra, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic sendToken(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e);
    bus.token_in      = {5'($urandom), e, a, p};
    bus.token_in_strb = 1'b1;
    tick();
    bus.token_in_strb = 1'b0;
  endtask

  task automatic modelReset();
    mAddr = '0;
    mConf = 1'b0;
    mPend = 0;
    mPendVal = '0;
    mLast = '0;
    setupQ.delete();
    txQ.delete();
  endtask

  // One SETUP transaction: token, n payload bytes, then end or fail pulse.
  task automatic applyStimulus(input logic [71:0] b, input int n, input logic [7:0] dpid,
                               input bit useFail, input logic [6:0] a, input logic [3:0] e);
    bit        hit;
    setupExp_t x;
    hit = (a == mAddr) && (e == 4'd0);
    if (hit) mPend = 0;
    if (hit && !useFail && n == 8 && dpid == PID_D0) begin
      x.bm = b[7:0];
      x.br = b[15:8];
      x.wv = {b[31:24], b[23:16]};
      x.wi = {b[47:40], b[39:32]};
      x.wl = {b[63:56], b[55:48]};
      if (x.bm == 8'd0 && x.wl == 16'd0 && x.br == 8'd5) mPend = 1;
      else if (x.bm == 8'd0 && x.wl == 16'd0 && x.br == 8'd9) mPend = 2;
      x.unsup  = (mPend == 0);
      mPendVal = x.wv;
      mLast    = x;
      setupQ.push_back(x);
    end
    sendToken(PID_SETUP, a, e);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      bus.data_in      = b[8*i +: 8];
      bus.pid          = dpid;
      bus.data_in_strb = 1'b1;
      tick();
      bus.data_in_strb = 1'b0;
    end
    if (useFail) bus.data_in_fail = 1'b1;
    else         bus.data_in_end  = 1'b1;
    tick();
    bus.data_in_fail = 1'b0;
    bus.data_in_end  = 1'b0;
    repeat (3) tick();
    checkOutput("setup_drain", 32'(setupQ.size()), 32'd0);
  endtask

  // Status-stage IN token; failAt 1/2 aborts the ZLP at t+1/t+2.
  task automatic statusIn(input int failAt, input logic [3:0] e);
    logic [6:0] oldAddr;
    bit         live;
    oldAddr = mAddr;
    live    = (mPend != 0) && (e == 4'd0);
    if (live) begin
      txQ.push_back(PID_D1);
      if (failAt != 1) txQ.push_back(8'h00);
    end
    sendToken(PID_IN, mAddr, e);
    if (failAt == 1) bus.data_o_fail = 1'b1;
    tick();
    bus.data_o_fail = 1'b0;
    checkOutput("addr_t2", 32'(bus.dev_addr), 32'(oldAddr));
    if (failAt == 2) bus.data_o_fail = 1'b1;
    tick();
    bus.data_o_fail = 1'b0;
    if (live && failAt == 0) begin
      if (mPend == 1) mAddr = mPendVal[6:0];
      else            mConf = (mPendVal[7:0] != 8'd0);
      mPend = 0;
    end
    checkOutput("addr_t3", 32'(bus.dev_addr), 32'(mAddr));
    checkOutput("configured", 32'(bus.configured), 32'(mConf));
    tick();
    checkOutput("tx_drain", 32'(txQ.size()), 32'd0);
  endtask

  task automatic checkFields();
    checkOutput("bm_request_type", 32'(bus.bm_request_type), 32'(mLast.bm));
    checkOutput("b_request", 32'(bus.b_request), 32'(mLast.br));
    checkOutput("w_value", 32'(bus.w_value), 32'(mLast.wv));
    checkOutput("w_index", 32'(bus.w_index), 32'(mLast.wi));
    checkOutput("w_length", 32'(bus.w_length), 32'(mLast.wl));
  endtask

  task automatic checkReset();
    checkFields();
    checkOutput("rst_dev_addr", 32'(bus.dev_addr), 32'd0);
    checkOutput("rst_configured", 32'(bus.configured), 32'd0);
    checkOutput("rst_setup_valid", 32'(bus.setup_valid), 32'd0);
    checkOutput("rst_req_unsupported", 32'(bus.req_unsupported), 32'd0);
    checkOutput("rst_start_stop", 32'(bus.data_o_start_stop), 32'd0);
    checkOutput("rst_data_o", 32'(bus.data_o), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    modelReset();
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a setup or a TX pulse.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("data_o_strb", 32'(bus.data_o_strb), 32'd0);
      checkOutput("unsup_without_valid", 32'(bus.req_unsupported & ~bus.setup_valid), 32'd0);
      if (!bus.data_o_start_stop) checkOutput("data_o_idle", 32'(bus.data_o), 32'd0);
      if (bus.setup_valid) begin
        if (setupQ.size() == 0) begin
          checkOutput("setup_unexpected", 32'(setupQ.size()), 32'd1);
        end else begin
          setupExp_t x;
          x = setupQ.pop_front();
          checkOutput("sv_bm_request_type", 32'(bus.bm_request_type), 32'(x.bm));
          checkOutput("sv_b_request", 32'(bus.b_request), 32'(x.br));
          checkOutput("sv_w_value", 32'(bus.w_value), 32'(x.wv));
          checkOutput("sv_w_index", 32'(bus.w_index), 32'(x.wi));
          checkOutput("sv_w_length", 32'(bus.w_length), 32'(x.wl));
          checkOutput("sv_req_unsupported", 32'(bus.req_unsupported), 32'(x.unsup));
        end
      end
      if (bus.data_o_start_stop) begin
        if (txQ.size() == 0) begin
          checkOutput("tx_unexpected", 32'(txQ.size()), 32'd1);
        end else begin
          logic [7:0] v;
          v = txQ.pop_front();
          checkOutput("tx_data_o", 32'(bus.data_o), 32'(v));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [71:0] b;
    int          n;
    int          kind;
    int          f;
    logic [7:0]  dpid;
    bit          fl;

    bus.token_in = '0;  bus.token_in_strb = 1'b0;
    bus.data_in  = '0;  bus.data_in_strb  = 1'b0;
    bus.data_in_end = 1'b0;  bus.data_in_fail = 1'b0;
    bus.pid = '0;  bus.data_o_fail = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    modelReset();
    checkReset();

    // SET_ADDRESS 0x2A with clean status stage
    applyStimulus(mk(8'h00, 8'h05, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(0, 4'd0);
    checkOutput("addr_2a", 32'(bus.dev_addr), 32'h2A);

    // status ZLP aborted at t+2, then retried
    applyStimulus(mk(8'h00, 8'h05, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(2, 4'd0);
    statusIn(0, 4'd0);
    // aborted at t+1, then retried
    applyStimulus(mk(8'h00, 8'h05, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(1, 4'd0);
    statusIn(0, 4'd0);

    // malformed SETUPs: short, long, DATA1, aborted
    b = mk(8'h00, 8'h05, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(b, 7, PID_D0, 1'b0, mAddr, 4'd0);  checkFields();  statusIn(0, 4'd0);
    applyStimulus(b, 9, PID_D0, 1'b0, mAddr, 4'd0);  checkFields();  statusIn(0, 4'd0);
    applyStimulus(b, 8, PID_D1, 1'b0, mAddr, 4'd0);  checkFields();  statusIn(0, 4'd0);
    applyStimulus(b, 8, PID_D0, 1'b1, mAddr, 4'd0);  checkFields();  statusIn(0, 4'd0);

    // GET_DESCRIPTOR is not handled here
    applyStimulus(mk(8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(0, 4'd0);

    // SET_CONFIGURATION with status timeout, then with IN
    applyStimulus(mk(8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    repeat (int'(TIMEOUT) + 5) tick();
    mPend = 0;
    statusIn(0, 4'd0);
    applyStimulus(mk(8'h00, 8'h09, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(0, 4'd0);
    checkOutput("configured_set", 32'(bus.configured), 32'd1);

    // new SETUP while in STATUS_IN replaces the pending SET_ADDRESS
    applyStimulus(mk(8'h00, 8'h05, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    applyStimulus(mk(8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(0, 4'd0);

    // tokens for another address or endpoint are ignored
    b = mk(8'h00, 8'h05, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(b, 8, PID_D0, 1'b0, mAddr ^ 7'h01, 4'd0);  checkFields();
    applyStimulus(b, 8, PID_D0, 1'b0, mAddr, 4'd1);          checkFields();
    applyStimulus(b, 8, PID_D0, 1'b0, mAddr, 4'd0);
    statusIn(0, 4'd3);
    statusIn(0, 4'd0);

    // randomized control transfers
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 5);
      b    = {8'($urandom), 32'($urandom), 32'($urandom)};
      n    = 8;
      dpid = PID_D0;
      fl   = 1'b0;
      case (kind)
        0: b = mk(8'h00, 8'h05, 8'($urandom_range(1, 127)), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        1: b = mk(8'h00, 8'h09, 8'($urandom_range(0, 3)), 8'h00, 8'($urandom), 8'h00, 8'h00, 8'h00);
        2: ;
        3: n = ($urandom_range(0, 1) == 0) ? 7 : 9;
        4: dpid = PID_D1;
        default: fl = 1'b1;
      endcase
      applyStimulus(b, n, dpid, fl, mAddr, 4'd0);
      f = $urandom_range(0, 3);
      statusIn((f == 3) ? 0 : f, 4'd0);
      if (f == 1 || f == 2) statusIn(0, 4'd0);
    end

    // reset in the middle of a SETUP packet
    sendToken(PID_SETUP, mAddr, 4'd0);
    for (int i = 0; i < 3; i++) begin
      bus.data_in = 8'($urandom);  bus.pid = PID_D0;  bus.data_in_strb = 1'b1;
      tick();
      bus.data_in_strb = 1'b0;
    end
    doReset();
    checkReset();

    checkOutput("final_setupQ", 32'(setupQ.size()), 32'd0);
    checkOutput("final_txQ", 32'(txQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
